// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the multi-master RAM arbiter.
package ram_arbiter_pkg;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_ADDR_WIDTH  = 8;
   localparam int DEF_NUM_MASTERS = 3;
   localparam int DEF_RD_LATENCY  = 1;
   localparam int DEF_MAX_HOLD    = 0;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_e;

   function automatic int wrap_inc(int v, int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle: requests, access fields, grants and read return.
interface ram_arbiter_if
   import ram_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH
);

   logic [NUM_MASTERS-1:0]                 req;
   logic [NUM_MASTERS-1:0]                 m_wren;
   logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr;
   logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata;
   logic [NUM_MASTERS-1:0]                 gnt;
   logic [NUM_MASTERS-1:0]                 rvalid;
   logic [DATA_WIDTH-1:0]                  rdata;

   modport master (
      output req, m_wren, m_addr, m_wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, m_wren, m_addr, m_wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational winner search: rotating start for round-robin, index 0
// start for fixed priority.
module rr_picker
   import ram_arbiter_pkg::*;
#(
   parameter int N  = DEF_NUM_MASTERS,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   input  logic          policy,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] base;
   logic [IW-1:0] cand;
   logic          found;

   assign base = policy ? '0 : start;
   assign any  = |req;

   always_comb begin
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand = IW'((int'(base) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: grant FSM, hold limiter and read-tag pipeline
// that routes returning read data to the master that issued the read.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int RD_LATENCY  = DEF_RD_LATENCY,
   parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           policy,
   ram_arbiter_if.slave                   bus,
   output logic                           ram_wren,
   output logic [ADDR_WIDTH-1:0]          ram_addr,
   output logic [DATA_WIDTH-1:0]          ram_wdata,
   input  logic [DATA_WIDTH-1:0]          ram_rdata,
   output logic [$clog2(NUM_MASTERS)-1:0] owner,
   output logic                           busy
);

   localparam int IW = $clog2(NUM_MASTERS);
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   typedef struct packed {
      logic          vld;
      logic [IW-1:0] idx;
   } tag_t;

   state_e                  state_q, state_d;
   logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
   logic [IW-1:0]           owner_q, owner_d;
   logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [HW-1:0]           hold_q, hold_d;
   tag_t [RD_LATENCY-1:0]   tag_q, tag_d;

   logic [IW-1:0] win_idx;
   logic          win_any;
   logic          own_req;
   logic          others;
   logic          limit_hit;
   logic          rd_fire;
   tag_t          tag_in;
   tag_t          tag_out;

   rr_picker #(
      .N  (NUM_MASTERS),
      .IW (IW)
   ) u_pick (
      .req    (bus.req),
      .start  (rr_ptr_q),
      .policy (policy),
      .idx    (win_idx),
      .any    (win_any)
   );

   assign own_req   = (state_q == GRANTED) & bus.req[owner_q];
   assign others    = |(bus.req & ~gnt_q);
   assign limit_hit = (MAX_HOLD > 0) && (int'(hold_q) + 1 >= MAX_HOLD);
   assign rd_fire   = own_req & ~bus.m_wren[owner_q];

   always_comb begin
      ram_wren  = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (state_q == GRANTED) begin
         ram_wren  = own_req & bus.m_wren[owner_q];
         ram_addr  = bus.m_addr[owner_q];
         ram_wdata = bus.m_wdata[owner_q];
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      hold_d   = hold_q;
      unique case (state_q)
         IDLE: begin
            if (win_any) begin
               state_d = GRANTED;
               owner_d = win_idx;
               gnt_d   = NUM_MASTERS'(1) << win_idx;
               hold_d  = '0;
            end
         end
         GRANTED: begin
            // voluntary drop or hold limit with a competitor waiting
            if (!own_req || (limit_hit && others)) begin
               state_d  = IDLE;
               gnt_d    = '0;
               owner_d  = '0;
               rr_ptr_d = IW'(wrap_inc(int'(owner_q), NUM_MASTERS));
            end else if (int'(hold_q) < MAX_HOLD) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tag_in.vld = rd_fire;
      tag_in.idx = owner_q;
      tag_d      = '0;
      tag_d[0]   = tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   assign tag_out    = tag_q[RD_LATENCY-1];
   assign bus.rvalid = tag_out.vld ? (NUM_MASTERS'(1) << tag_out.idx) : '0;
   assign bus.rdata  = ram_rdata;
   assign bus.gnt    = gnt_q;
   assign owner      = owner_q;
   assign busy       = (state_q == GRANTED);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         hold_q   <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         hold_q   <= hold_d;
         tag_q    <= tag_d;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a queue-based
// behavioural model of grants, RAM contents and read returns.
module tb_ram_arbiter;

   localparam int NM = 3;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int RL = 2;
   localparam int MH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          policy;
   logic          ram_wren;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic [1:0]    owner;
   logic          busy;

   ram_arbiter_if #(
      .NUM_MASTERS (NM),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW)
   ) bus ();

   ram_arbiter #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .NUM_MASTERS (NM),
      .RD_LATENCY  (RL),
      .MAX_HOLD    (MH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .policy    (policy),
      .bus       (bus),
      .ram_wren  (ram_wren),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .owner     (owner),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // RAM environment with RL-cycle read latency
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_pipe [RL];

   always @(posedge clk) begin
      for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= mem[ram_addr];
      if (ram_wren) mem[ram_addr] = ram_wdata;
   end

   assign ram_rdata = rd_pipe[RL-1];

   // reference model state
   typedef struct {
      int          due;
      int          who;
      logic [7:0]  data;
   } rd_t;

   int         m_own;
   int         m_rr;
   int         m_hold;
   int         cyc;
   logic [7:0] m_mem [256];
   rd_t        rdq [$];

   int n_chk  = 0;
   int n_pass = 0;

   logic [NM-1:0][AW-1:0] s_addr;
   logic [NM-1:0][DW-1:0] s_wdata;
   logic [NM-1:0]         obs_gnt;
   logic [NM-1:0]         obs_rvalid;
   logic [DW-1:0]         obs_rdata;
   logic [NM-1:0]         prev_gnt;
   int                    idle_run;
   int                    order [$];
   int                    gaps [$];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int pick(logic [NM-1:0] rq, logic pol);
      for (int k = 0; k < NM; k++) begin
         int c;
         c = pol ? k : (m_rr + k) % NM;
         if (rq[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_own  = -1;
      m_rr   = 0;
      m_hold = 0;
      rdq.delete();
   endtask

   task automatic step(logic [NM-1:0] rq, logic [NM-1:0] wr, logic pol);
      logic [NM-1:0] eg;
      logic [NM-1:0] er;
      logic [DW-1:0] ed;
      logic          acc;
      int            own;
      @(negedge clk);
      bus.req     = rq;
      bus.m_wren  = wr;
      bus.m_addr  = s_addr;
      bus.m_wdata = s_wdata;
      policy      = pol;
      #1;
      own = m_own;
      eg  = '0;
      if (own >= 0) eg[own] = 1'b1;
      acc = (own >= 0) && rq[own];
      chk("gnt", bus.gnt, eg);
      chk("owner", owner, (own >= 0) ? own : 0);
      chk("busy", busy, own >= 0);
      chk("ram_wren", ram_wren, acc && wr[own]);
      chk("ram_addr", ram_addr, (own >= 0) ? s_addr[own] : 0);
      chk("ram_wdata", ram_wdata, (own >= 0) ? s_wdata[own] : 0);
      er = '0;
      ed = '0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
         er[rdq[0].who] = 1'b1;
         ed = rdq[0].data;
         void'(rdq.pop_front());
      end
      chk("rvalid", bus.rvalid, er);
      if (er != 0) chk("rdata", bus.rdata, ed);
      obs_gnt    = bus.gnt;
      obs_rvalid = bus.rvalid;
      obs_rdata  = bus.rdata;
      if (obs_gnt == 0) idle_run++;
      else if (prev_gnt == 0) begin
         for (int i = 0; i < NM; i++) if (obs_gnt[i]) order.push_back(i);
         gaps.push_back(idle_run);
         idle_run = 0;
      end
      prev_gnt = obs_gnt;
      // advance model to the next cycle
      if (acc && !wr[own])
         rdq.push_back('{due: cyc + RL, who: own, data: m_mem[s_addr[own]]});
      if (acc && wr[own]) m_mem[s_addr[own]] = s_wdata[own];
      if (own < 0) begin
         if (rq != 0) begin
            m_own  = pick(rq, pol);
            m_hold = 0;
         end
      end else begin
         m_hold++;
         if (!rq[own] ||
             (MH > 0 && m_hold >= MH && (rq & ~(NM'(1) << own)) != 0)) begin
            m_rr  = (own + 1) % NM;
            m_own = -1;
         end
      end
      cyc++;
   endtask

   initial begin
      logic [NM-1:0] want;
      logic          pol;
      int            exp_ord [4];
      int            got;
      exp_ord = '{0, 1, 2, 0};
      reset       = 1'b1;
      policy      = 1'b0;
      bus.req     = '0;
      bus.m_wren  = '0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      s_addr      = '0;
      s_wdata     = '0;
      prev_gnt    = '0;
      idle_run    = 0;
      cyc         = 0;
      for (int a = 0; a < 256; a++) begin
         mem[a]   = 8'(a) ^ 8'h3C;
         m_mem[a] = 8'(a) ^ 8'h3C;
      end
      mem[8'h40]   = 8'hA5;
      m_mem[8'h40] = 8'hA5;
      model_reset();

      repeat (2) @(negedge clk);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      reset = 1'b0;

      // round-robin rotation with one idle cycle per handover
      order.delete();
      gaps.delete();
      for (int k = 0; k < NM; k++) begin
         step(3'b111, 3'b000, 1'b0);
         step(3'b111, 3'b000, 1'b0);
         step(3'b111, 3'b000, 1'b0);
         step(3'b111 ^ (NM'(1) << k), 3'b000, 1'b0);
      end
      step(3'b111, 3'b000, 1'b0);
      step(3'b111, 3'b000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         got = (i < order.size()) ? order[i] : -1;
         chk($sformatf("rr_order%0d", i), got, exp_ord[i]);
      end
      for (int i = 1; i < 4; i++) begin
         got = (i < gaps.size()) ? gaps[i] : -1;
         chk($sformatf("rr_gap%0d", i), got, 1);
      end
      step(3'b110, 3'b000, 1'b0);
      step(3'b000, 3'b000, 1'b0);

      // fixed priority: owner keeps grant, then lowest index wins
      step(3'b110, 3'b000, 1'b1);
      step(3'b110, 3'b000, 1'b1);
      chk("fp_first", obs_gnt, 3'b010);
      step(3'b111, 3'b000, 1'b1);
      chk("fp_keep", obs_gnt, 3'b010);
      step(3'b111, 3'b000, 1'b1);
      step(3'b101, 3'b000, 1'b1);
      step(3'b101, 3'b000, 1'b1);
      step(3'b101, 3'b000, 1'b1);
      chk("fp_win0", obs_gnt, 3'b001);
      step(3'b000, 3'b000, 1'b1);
      step(3'b000, 3'b000, 1'b1);

      // master 2 read with two-cycle latency
      s_addr[2] = 8'h40;
      step(3'b100, 3'b000, 1'b0);
      step(3'b100, 3'b000, 1'b0);
      step(3'b000, 3'b000, 1'b0);
      chk("rd_early", obs_rvalid, 3'b000);
      step(3'b000, 3'b000, 1'b0);
      chk("rd_rvalid", obs_rvalid, 3'b100);
      chk("rd_rdata", obs_rdata, 8'hA5);

      // hold limit forces a handover
      step(3'b001, 3'b000, 1'b0);
      for (int i = 0; i < MH; i++) begin
         step(3'b011, 3'b000, 1'b0);
         chk($sformatf("hold_g0_%0d", i), obs_gnt, 3'b001);
      end
      step(3'b011, 3'b000, 1'b0);
      chk("hold_idle", obs_gnt, 3'b000);
      step(3'b011, 3'b000, 1'b0);
      chk("hold_g1", obs_gnt, 3'b010);
      step(3'b000, 3'b000, 1'b0);
      step(3'b000, 3'b000, 1'b0);

      // write by master 0 then read back by master 1
      s_addr[0]  = 8'h05;
      s_wdata[0] = 8'h11;
      step(3'b001, 3'b001, 1'b0);
      step(3'b001, 3'b001, 1'b0);
      step(3'b000, 3'b000, 1'b0);
      step(3'b000, 3'b000, 1'b0);
      s_addr[1] = 8'h05;
      step(3'b010, 3'b000, 1'b0);
      step(3'b010, 3'b000, 1'b0);
      step(3'b000, 3'b000, 1'b0);
      step(3'b000, 3'b000, 1'b0);
      chk("wr_rd_rvalid", obs_rvalid, 3'b010);
      chk("wr_rd_rdata", obs_rdata, 8'h11);

      // reset with a read tag in flight
      s_addr[0] = 8'h07;
      step(3'b001, 3'b000, 1'b0);
      step(3'b001, 3'b000, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_gnt", bus.gnt, 0);
      chk("arst_busy", busy, 0);
      chk("arst_owner", owner, 0);
      chk("arst_rvalid", bus.rvalid, 0);
      bus.req = '0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(3'b000, 3'b000, 1'b0);
      chk("arst_no_rvalid", obs_rvalid, 3'b000);
      step(3'b000, 3'b000, 1'b0);

      // randomized traffic
      want = '0;
      pol  = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NM; i++) begin
            if (want[i]) want[i] = ($urandom_range(0, 4) != 0);
            else         want[i] = ($urandom_range(0, 2) == 0);
            s_addr[i]  = 8'($urandom_range(0, 15));
            s_wdata[i] = 8'($urandom);
         end
         if ($urandom_range(0, 9) == 0) pol = ~pol;
         step(want, 3'($urandom), pol);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 Parameter ADDR_WIDTH, default 8, RAM address width.
REQ-003 Parameter NUM_MASTERS, default 3, requester count (>=2).
REQ-004 Parameter RD_LATENCY, default 1, RAM read latency in cycles (>=1).
REQ-005 Parameter MAX_HOLD, default 0, max consecutive granted cycles while another master waits; 0 = unlimited.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 policy  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-009 req  input  NUM_MASTERS  per-master access request, level.
REQ-010 m_wren  input  NUM_MASTERS  per-master write enable.
REQ-011 m_addr  input  NUM_MASTERS x ADDR_WIDTH  per-master address.
REQ-012 m_wdata  input  NUM_MASTERS x DATA_WIDTH  per-master write data.
REQ-013 gnt  output  NUM_MASTERS  one-hot-or-zero grant.
REQ-014 rvalid  output  NUM_MASTERS  per-master read-data-valid strobe.
REQ-015 rdata  output  DATA_WIDTH  read data, broadcast to all masters.
REQ-016 ram_wren / ram_addr / ram_wdata  output  1 / ADDR_WIDTH / DATA_WIDTH  RAM port.
REQ-017 ram_rdata  input  DATA_WIDTH  RAM read data.
REQ-018 owner  output  clog2(NUM_MASTERS)  index of current grantee, 0 when idle.
REQ-019 busy  output  1  high while any grant is held.

Function
REQ-020 FSM states IDLE and GRANTED; reset state IDLE.
REQ-021 IDLE with any req: winner chosen per policy, gnt[winner] registered next cycle, state GRANTED.
REQ-022 Round-robin: search starts at rr_ptr, wraps modulo NUM_MASTERS; rr_ptr = winner+1 (wrap to 0 after NUM_MASTERS-1) on each release.
REQ-023 policy sampled only in IDLE; changes while GRANTED take effect at next arbitration.
REQ-024 GRANTED: ram_wren/ram_addr/ram_wdata combinationally driven from owner's m_* signals; ram_wren = req[owner] & m_wren[owner].
REQ-025 No grant: ram_wren = 0, ram_addr = 0, ram_wdata = 0.
REQ-026 Grant held while req[owner] high; req[owner] low -> gnt cleared next edge, state IDLE; each handover costs exactly one IDLE cycle.
REQ-027 MAX_HOLD>0: hold counter counts granted cycles; at MAX_HOLD with another req pending, grant revoked next edge (forced release, rr_ptr advanced); counter clears on every new grant.
REQ-028 MAX_HOLD reached with no other req pending: grant kept, counter saturates.
REQ-029 Granted read (gnt & req & !m_wren of owner) launches a tag (valid + owner index) into a RD_LATENCY-deep shift register.
REQ-030 rvalid[tag owner] asserted for one cycle exactly RD_LATENCY cycles after the read cycle; rdata = ram_rdata.
REQ-031 Tags in flight complete even if grant released or transferred; reads by different owners never merge.
REQ-032 Granted cycle with req[owner] low (release cycle) issues no RAM access.
REQ-033 gnt never has more than one bit set; gnt only changes on clock edges.

Reset
REQ-034 Reset asserted: gnt=0, rvalid=0, busy=0, owner=0, rr_ptr=0, hold counter=0, tag pipeline cleared, state IDLE, immediately and asynchronously.
REQ-035 Reset mid-read: pending rvalid strobes discarded; no rvalid for 1+ cycles after deassertion.
REQ-036 First arbitration no earlier than first rising edge after reset deassertion.

Structure
REQ-037 Package ram_arbiter_pkg holds state enum and default width/count constants.
REQ-038 Sub-module rr_picker: combinational priority search given req, start pointer and policy, returns winner index and any-valid.
REQ-039 Tag pipeline and hold counter implemented in ram_arbiter top.

Verification
REQ-040 req=3'b111, policy=0, each master holds 2 cycles then drops -> grant order 0,1,2,0; one IDLE cycle between grants.
REQ-041 policy=1, req=3'b110 then req[0] raised while 1 granted -> 1 keeps grant until release, then 0 wins over 2.
REQ-042 Master 2 reads addr 8'h40, RAM returns 8'hA5, RD_LATENCY=2 -> rvalid[2] high exactly 2 cycles after read cycle, rdata=8'hA5; rvalid[0],[1] low.
REQ-043 MAX_HOLD=4, master 0 holds req, master 1 requests -> gnt[0] revoked after 4 granted cycles, gnt[1] granted after one IDLE cycle.
REQ-044 Master 0 writes 8'h11 to 8'h05, releases; master 1 reads 8'h05 -> master 1 receives 8'h11.
REQ-045 Reset asserted with read tag in flight -> gnt=0, no rvalid emitted, busy=0 within same cycle.
